// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address and holds the IF/ID pipeline register. Handles decode redirects,
// hazard-unit stalls/flushes and a sticky halt raised by the exit syscall.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0040_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall_F,
   input  logic        stall_D,
   input  logic        flush_D,
   input  logic        pc_src,
   input  logic [31:0] jump_address,
   input  logic        halt_request,
   output logic [31:0] instr_mem_addr,
   input  logic [31:0] instr_mem_data,
   output logic [31:0] pc_F,
   output logic [31:0] instruction_D,
   output logic [31:0] pc_plus_four_D,
   output logic        valid_D,
   output logic        halted,
   output logic [31:0] fetch_count
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] instr_reg, instr_next;
   logic [31:0] ppf_reg, ppf_next;
   logic        valid_reg, valid_next;
   logic [31:0] count_reg, count_next;

   logic [31:0] pc_plus_four;
   logic        redirect;
   logic        halt_take;
   logic        squash;

   // Decode-side requests are only trusted when decode is not stalled,
   // because its operands may be stale while it waits.
   always_comb begin
      pc_plus_four = pc_reg + 32'd4;
      redirect     = pc_src & ~stall_D;
      halt_take    = halt_request & ~stall_D & (state_reg == RUN);
      squash       = redirect | flush_D | halt_take;
   end

   // Next-state logic for the run/halt FSM, the PC and the IF/ID register.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      instr_next = instr_reg;
      ppf_next   = ppf_reg;
      valid_next = valid_reg;
      count_next = count_reg;

      if (halt_take) begin
         state_next = HALTED;
      end

      // PC: halt freezes, stall_F holds (and wins over a redirect),
      // otherwise redirect or sequential fetch with natural 32-bit wrap.
      if ((state_reg == HALTED) || halt_take) begin
         pc_next = pc_reg;
      end else if (stall_F) begin
         pc_next = pc_reg;
      end else if (redirect) begin
         pc_next = jump_address;
      end else begin
         pc_next = pc_plus_four;
      end

      // IF/ID: stall holds, halt/squash inserts a bubble, otherwise load.
      if (stall_D) begin
         instr_next = instr_reg;
         ppf_next   = ppf_reg;
         valid_next = valid_reg;
      end else if ((state_reg == HALTED) || squash) begin
         instr_next = NOP_INSTR;
         ppf_next   = 32'd0;
         valid_next = 1'b0;
      end else begin
         instr_next = instr_mem_data;
         ppf_next   = pc_plus_four;
         valid_next = 1'b1;
         count_next = count_reg + 32'd1;
      end
   end

   // State registers; reset overrides every other request on its edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= RUN;
         pc_reg    <= RESET_PC;
         instr_reg <= NOP_INSTR;
         ppf_reg   <= 32'd0;
         valid_reg <= 1'b0;
         count_reg <= 32'd0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         instr_reg <= instr_next;
         ppf_reg   <= ppf_next;
         valid_reg <= valid_next;
         count_reg <= count_next;
      end
   end

   assign pc_F           = pc_reg;
   assign instr_mem_addr = pc_reg;
   assign instruction_D  = instr_reg;
   assign pc_plus_four_D = ppf_reg;
   assign valid_D        = valid_reg;
   assign halted         = (state_reg == HALTED);
   assign fetch_count    = count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns its own address as data.
module tb_fetch_stage;

   logic        clock = 1'b0;
   logic        reset, stall_F, stall_D, flush_D, pc_src, halt_request;
   logic [31:0] jump_address;
   logic [31:0] instr_mem_addr, instr_mem_data, pc_F, instruction_D, pc_plus_four_D, fetch_count;
   logic        valid_D, halted;

   // second instance exercising PC wrap-around
   logic        reset2, z_stall_F, z_stall_D, z_flush_D, z_pc_src, z_halt;
   logic [31:0] z_jump;
   logic [31:0] addr2, data2, pc2, instr2, ppf2, count2;
   logic        valid2, halted2;

   int total_checks  = 0;
   int passed_checks = 0;

   always #5 clock = ~clock;

   assign instr_mem_data = instr_mem_addr;
   assign data2          = addr2;

   fetch_stage dut (
      .clock(clock), .reset(reset), .stall_F(stall_F), .stall_D(stall_D),
      .flush_D(flush_D), .pc_src(pc_src), .jump_address(jump_address),
      .halt_request(halt_request), .instr_mem_addr(instr_mem_addr),
      .instr_mem_data(instr_mem_data), .pc_F(pc_F), .instruction_D(instruction_D),
      .pc_plus_four_D(pc_plus_four_D), .valid_D(valid_D), .halted(halted),
      .fetch_count(fetch_count)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clock(clock), .reset(reset2), .stall_F(z_stall_F), .stall_D(z_stall_D),
      .flush_D(z_flush_D), .pc_src(z_pc_src), .jump_address(z_jump),
      .halt_request(z_halt), .instr_mem_addr(addr2),
      .instr_mem_data(data2), .pc_F(pc2), .instruction_D(instr2),
      .pc_plus_four_D(ppf2), .valid_D(valid2), .halted(halted2),
      .fetch_count(count2)
   );

   // A redirect with stall_F but no stall_D is outside the hazard-unit contract.
   always @(posedge clock) begin
      if (!reset && pc_src && stall_F && !stall_D)
         $error("FAIL protocol: pc_src with stall_F and no stall_D");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_checks++;
      assert (obs === exp) passed_checks++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [31:0] ppf, input logic v, input logic [31:0] cnt);
      check({tag, " pc_F"}, pc_F, pc);
      check({tag, " addr"}, instr_mem_addr, pc);
      check({tag, " instr"}, instruction_D, ins);
      check({tag, " ppf"}, pc_plus_four_D, ppf);
      check({tag, " valid"}, {31'd0, valid_D}, {31'd0, v});
      check({tag, " count"}, fetch_count, cnt);
      $display("step %-10s pc=%h instr=%h ppf=%h v=%0b cnt=%0d halted=%0b",
               tag, pc_F, instruction_D, pc_plus_four_D, valid_D, fetch_count, halted);
   endtask

   initial begin
      reset = 1'b1; stall_F = 1'b0; stall_D = 1'b0; flush_D = 1'b0;
      pc_src = 1'b0; halt_request = 1'b0; jump_address = 32'h0;
      reset2 = 1'b1; z_stall_F = 1'b0; z_stall_D = 1'b0; z_flush_D = 1'b0;
      z_pc_src = 1'b0; z_halt = 1'b0; z_jump = 32'h0;

      step(); step();
      check_ifid("reset", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd0);
      check("reset halted", {31'd0, halted}, 32'd0);
      check("wrap reset pc", pc2, 32'hFFFF_FFF8);

      reset = 1'b0; reset2 = 1'b0;
      step();
      check_ifid("run1", 32'h0040_0004, 32'h0040_0000, 32'h0040_0004, 1'b1, 32'd1);
      check("wrap pc1", pc2, 32'hFFFF_FFFC);
      check("wrap ppf1", ppf2, 32'hFFFF_FFFC);
      step();
      check_ifid("run2", 32'h0040_0008, 32'h0040_0004, 32'h0040_0008, 1'b1, 32'd2);
      check("wrap pc2", pc2, 32'h0000_0000);
      check("wrap instr2", instr2, 32'hFFFF_FFFC);
      check("wrap ppf2", ppf2, 32'h0000_0000);
      reset2 = 1'b1;

      // redirect at pc_F = 0x0040_0008
      pc_src = 1'b1; jump_address = 32'h0040_0100;
      step();
      check_ifid("redir", 32'h0040_0100, 32'h0, 32'h0, 1'b0, 32'd2);
      pc_src = 1'b0; jump_address = 32'h0;
      step();
      check_ifid("target", 32'h0040_0104, 32'h0040_0100, 32'h0040_0104, 1'b1, 32'd3);

      // full stall with a redirect that must be ignored
      stall_F = 1'b1; stall_D = 1'b1; pc_src = 1'b1; jump_address = 32'h0040_0200;
      for (int i = 0; i < 3; i++) begin
         step();
         check_ifid("stall", 32'h0040_0104, 32'h0040_0100, 32'h0040_0104, 1'b1, 32'd3);
      end
      stall_F = 1'b0; stall_D = 1'b0; pc_src = 1'b0;
      step();
      check_ifid("resume", 32'h0040_0108, 32'h0040_0104, 32'h0040_0108, 1'b1, 32'd4);

      // flush alone
      flush_D = 1'b1;
      step();
      check_ifid("flush", 32'h0040_010C, 32'h0, 32'h0, 1'b0, 32'd4);
      flush_D = 1'b0;
      step();
      check_ifid("postflush", 32'h0040_0110, 32'h0040_010C, 32'h0040_0110, 1'b1, 32'd5);

      // halt request under stall_D is ignored
      halt_request = 1'b1; stall_D = 1'b1; stall_F = 1'b1;
      step();
      check_ifid("haltstall", 32'h0040_0110, 32'h0040_010C, 32'h0040_0110, 1'b1, 32'd5);
      check("haltstall halted", {31'd0, halted}, 32'd0);

      // halt taken
      stall_D = 1'b0; stall_F = 1'b0;
      step();
      check_ifid("halt", 32'h0040_0110, 32'h0, 32'h0, 1'b0, 32'd5);
      check("halt halted", {31'd0, halted}, 32'd1);
      halt_request = 1'b0;
      for (int i = 0; i < 20; i++) begin
         pc_src = i[0]; jump_address = 32'h0040_0300 + 32'(i * 4); flush_D = i[1];
         step();
         check_ifid("halted", 32'h0040_0110, 32'h0, 32'h0, 1'b0, 32'd5);
         check("halted flag", {31'd0, halted}, 32'd1);
      end

      // reset overrides stall/redirect/halt
      reset = 1'b1; stall_F = 1'b1; stall_D = 1'b1; pc_src = 1'b1; halt_request = 1'b1;
      step();
      check_ifid("rst2", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 32'd0);
      check("rst2 halted", {31'd0, halted}, 32'd0);
      reset = 1'b0; stall_F = 1'b0; stall_D = 1'b0; pc_src = 1'b0; halt_request = 1'b0;
      flush_D = 1'b0;
      step();
      check_ifid("rerun", 32'h0040_0004, 32'h0040_0000, 32'h0040_0004, 1'b1, 32'd1);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipelined MIPS core. It owns the program counter and drives the instruction-memory read address. It holds the IF/ID pipeline register, which feeds the decode stage its `instruction` and `pc_plus_four`. It applies decode-stage redirects, hazard-unit stalls and flushes, and a sticky halt raised by the exit syscall.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC value loaded on reset (MIPS text base).
- `NOP_INSTR`, default 32'h0000_0000: bubble encoding inserted into IF/ID (`sll $0,$0,0`).
- `clock`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `stall_F`  in  1: hazard unit; hold PC.
- `stall_D`  in  1: hazard unit; hold IF/ID contents.
- `flush_D`  in  1: hazard unit; load bubble into IF/ID.
- `pc_src`  in  1: decode; redirect PC to `jump_address`.
- `jump_address`  in  32: decode; redirect target.
- `halt_request`  in  1: decode; exit syscall in D.
- `instr_mem_addr`  out  32: instruction memory read address; always equals `pc_F`.
- `instr_mem_data`  in  32: instruction memory read data; combinational, valid the same cycle.
- `pc_F`  out  32: current fetch PC.
- `instruction_D`  out  32: IF/ID instruction, to decode.
- `pc_plus_four_D`  out  32: IF/ID PC+4, to decode.
- `valid_D`  out  1: IF/ID holds a real (non-bubble) instruction.
- `halted`  out  1: fetch permanently stopped.
- `fetch_count`  out  32: number of valid instructions loaded into IF/ID.

## Operation
- State machine has two states: RUN and HALTED. Reset enters RUN. Only reset leaves HALTED.
- `redirect = pc_src & ~stall_D`. `squash = redirect | flush_D | halt_take`. `halt_take = halt_request & ~stall_D & (state==RUN)`.
- PC next-value priority:
  - reset: `RESET_PC`.
  - HALTED, or `halt_take`: hold.
  - `stall_F`: hold.
  - `redirect`: `jump_address`.
  - otherwise: `pc_F + 4`, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- A redirect never coexists with `stall_F` without `stall_D`; the hazard unit guarantees this. If it does occur, `stall_F` wins and the redirect is lost. The bench flags this as an assertion.
- IF/ID next-value priority:
  - reset: bubble.
  - `stall_D`: hold.
  - HALTED or `squash`: bubble.
  - otherwise: load `{instr_mem_data, pc_F + 4}` with valid=1.
- Bubble means `instruction_D = NOP_INSTR`, `pc_plus_four_D = 0`, `valid_D = 0`.
- There is no branch delay slot. The instruction fetched in the redirect cycle is squashed.
- `fetch_count` increments by 1 on every edge that loads IF/ID with valid=1. It wraps at 2^32 and resets to 0.
- `pc_src` and `jump_address` are ignored while `stall_D=1`, because decode operands may be stale.
- `halt_request` is ignored while `stall_D=1`.
- The `pc_src`/`jump_address` inputs, and all other inputs, are ignored in HALTED.

## Timing
- Reset values:
  - `pc_F = RESET_PC`
  - `instruction_D = NOP_INSTR`
  - `pc_plus_four_D = 0`
  - `valid_D = 0`
  - `halted = 0`
  - `fetch_count = 0`
- The first fetch from `RESET_PC` happens in the first cycle after `reset` deasserts. Its instruction is in IF/ID one edge later.
- Latency is one cycle from `pc_F` to `instruction_D`. Sustained throughput is one instruction per cycle.
- On redirect, the target is in `pc_F` on the next cycle. The target instruction appears in IF/ID two edges after the redirect cycle, with one bubble between.
- `halted` rises on the edge after `halt_take`. From that edge on, `valid_D = 0` permanently and `pc_F` is frozen.
- Reset asserted mid-operation overrides everything on that edge, including stall, halt and redirect.

## Test plan
- Reset then free-run with memory word = address: `instruction_D` sequence is 0x0040_0000, 0x0040_0004, …; `pc_plus_four_D = instruction_D + 4`; `fetch_count = 3` after 3 valid loads.
- `pc_src=1` with `jump_address = 0x0040_0100` at `pc_F = 0x0040_0008`: next `pc_F = 0x0040_0100`; IF/ID shows one bubble (`valid_D = 0`), then 0x0040_0100.
- `stall_F = stall_D = 1` for 3 cycles with `pc_src = 1`: `pc_F` and IF/ID are unchanged for 3 cycles and the redirect is ignored. After release, sequential fetch resumes from the held PC.
- `flush_D` alone for one cycle: IF/ID becomes a bubble, the PC advances by 4, and `fetch_count` does not increment for that edge.
- `halt_request` pulse: `halted = 1` on the next edge. The PC holds and `valid_D` stays 0 for 20 cycles despite `pc_src` toggling. Reset returns to `RESET_PC` in RUN.
- Start at `RESET_PC = 32'hFFFF_FFF8` and run 3 cycles: `pc_F` goes 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, and the last loaded `pc_plus_four_D` is 0x0000_0000.
